// File: rtl/sprite_pkg.sv
// Sprite ROM address/word layout shared by the sprite renderers and the ROM arbiter.
// Holds tile geometry, the ROM word field positions and the sprite id table.
package sprite_pkg;

    localparam int TILE_SIZE   = 16;
    localparam int SPRITE_ID_W = 4;
    localparam int PIX_IDX_W   = 8;
    localparam int SPR_ADDR_W  = SPRITE_ID_W + PIX_IDX_W;
    localparam int SPR_DATA_W  = 13;

    // ROM word: {mask, r[3:0], g[3:0], b[3:0]}
    localparam int MASK_BIT = 12;
    localparam int R_HI = 11, R_LO = 8;
    localparam int G_HI = 7,  G_LO = 4;
    localparam int B_HI = 3,  B_LO = 0;

    typedef enum logic [SPRITE_ID_W-1:0] {
        SPR_DOT          = 4'd0,
        SPR_BIG_DOT      = 4'd1,
        SPR_PACMAN_F1    = 4'd2,
        SPR_PACMAN_F2    = 4'd3,
        SPR_GHOST_F1     = 4'd4,
        SPR_GHOST_F2     = 4'd5,
        SPR_EYE_UP       = 4'd6,
        SPR_EYE_DOWN     = 4'd7,
        SPR_EYE_LEFT     = 4'd8,
        SPR_EYE_RIGHT    = 4'd9,
        SPR_SCLERA_UP    = 4'd10,
        SPR_SCLERA_DOWN  = 4'd11,
        SPR_SCLERA_LEFT  = 4'd12,
        SPR_SCLERA_RIGHT = 4'd13
    } sprite_id_e;

    typedef struct packed {
        logic       mask;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } sprite_px_t;

    function automatic logic [SPR_ADDR_W-1:0] sprite_addr(input sprite_id_e id,
                                                          input logic [PIX_IDX_W-1:0] pix);
        return {id, pix};
    endfunction

endpackage

// File: rtl/sprite_arb_pick.sv
// Picks one of the low-priority requesters 1..NUM_REQ-1 as a one-hot vector.
// SPRITE_ARB_RR_EN selects round-robin from a start pointer; otherwise lowest index wins.
module sprite_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:1] pend_i,
`ifdef SPRITE_ARB_RR_EN
    input  logic [PTR_W-1:0]   ptr_i,
`endif
    output logic [NUM_REQ-1:1] pick_o
);

`ifdef SPRITE_ARB_RR_EN
    always_comb begin
        logic found;
        int   start;
        int   idx;
        pick_o = '0;
        found  = 1'b0;
        start  = int'(ptr_i);
        // The pointer never legally holds 0 or an out-of-range index; fall back to 1.
        if (start < 1 || start > NUM_REQ - 1) start = 1;
        for (int off = 0; off < NUM_REQ - 1; off++) begin
            idx = ((start - 1 + off) % (NUM_REQ - 1)) + 1;
            if (!found && pend_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        pick_o = '0;
        found  = 1'b0;
        for (int i = 1; i < NUM_REQ; i++) begin
            if (!found && pend_i[i]) begin
                pick_o[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Time-multiplexes one single-port sprite ROM across NUM_REQ requesters, index 0 preferred.
// Build option SPRITE_ARB_RR_EN: round-robin among requesters 1..N-1 (default: fixed priority).
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = SPR_ADDR_W,
    parameter int DATA_W     = SPR_DATA_W,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [7:0]         starve_q, starve_d;
    logic               lo_pend;
    logic               force_slot;
    logic [NUM_REQ-1:1] lo_pick;
    logic [NUM_REQ-1:0] tag_q [ROM_LAT];

    assign lo_pend    = |req[NUM_REQ-1:1];
    assign force_slot = req[0] & lo_pend & (starve_q == 8'(STARVE_MAX));

`ifdef SPRITE_ARB_RR_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    sprite_arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .pend_i (req[NUM_REQ-1:1]),
        .ptr_i  (rr_ptr_q),
        .pick_o (lo_pick)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int k = 1; k < NUM_REQ; k++) begin
            if (gnt[k]) rr_ptr_d = (k == NUM_REQ - 1) ? PTR_W'(1) : PTR_W'(k + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= PTR_W'(1);
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    sprite_arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .pend_i (req[NUM_REQ-1:1]),
        .pick_o (lo_pick)
    );
`endif

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (req[0] && !force_slot) gnt[0] = 1'b1;
            else if (lo_pend)          gnt[NUM_REQ-1:1] = lo_pick;
        end
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) rom_addr = rom_addr | req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign rom_en = |gnt;

    // Counts display-pipe wins over waiting renderers; saturates so the forced slot holds.
    always_comb begin
        starve_d = starve_q;
        if (gnt[0] && lo_pend) begin
            if (starve_q < 8'(STARVE_MAX)) starve_d = starve_q + 8'd1;
        end else if ((|gnt[NUM_REQ-1:1]) || !lo_pend) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            for (int s = 0; s < ROM_LAT; s++) tag_q[s] <= '0;
        end else begin
            starve_q <= starve_d;
            tag_q[0] <= gnt;
            for (int s = 1; s < ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Masked during rst so a read issued just before reset never surfaces.
    assign rsp_valid = rst ? '0 : tag_q[ROM_LAT-1];
    assign rsp_data  = (|rsp_valid) ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: vector table, directed corner sequences,
// and a grant/response scoreboard running under random back-to-back traffic.
module tb_sprite_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 12;
    localparam int DW   = 13;
    localparam int LAT  = 3;
    localparam int SMAX = 3;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   gnt;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [NREQ-1:0] last_gnt = '0;

    sprite_rom_arbiter #(
        .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {a[3:0], a[11:3]} ^ 13'h0A5;
    endfunction

    // ROM model with LAT-cycle read latency
    logic [AW-1:0] ap [LAT];
    always @(posedge clk) begin
        ap[0] <= rom_addr;
        for (int s = 1; s < LAT; s++) ap[s] <= ap[s-1];
    end
    assign rom_data = rom_word(ap[LAT-1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: grants push expected responses, responses pop and compare.
    typedef struct {
        logic [NREQ-1:0] idx;
        logic [AW-1:0]   addr;
        int              due;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        exp_t ne;
        logic [NREQ-1:0] exp_v;
        logic [DW-1:0]   exp_d;
        logic [AW-1:0]   gaddr;
        cyc++;
        if (rst) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_gnt", 32'(gnt), 32'(0));
            sbq.delete();
        end else begin
            exp_v = '0;
            exp_d = '0;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e     = sbq.pop_front();
                exp_v = e.idx;
                exp_d = rom_word(e.addr);
            end
            if (rsp_valid != 0 || exp_v != 0) begin
                chk("sb_rsp_valid", 32'(rsp_valid), 32'(exp_v));
                chk("sb_rsp_data", 32'(rsp_data), 32'(exp_d));
            end
            if (gnt != 0) begin
                chk("gnt_onehot", 32'($countones(gnt)), 32'(1));
                chk("gnt_without_req", 32'(gnt & ~req), 32'(0));
                chk("rom_en", 32'(rom_en), 32'(1));
                gaddr = '0;
                for (int i = 0; i < NREQ; i++)
                    if (gnt[i]) gaddr = req_addr[i*AW +: AW];
                ne.idx  = gnt;
                ne.addr = gaddr;
                ne.due  = cyc + LAT;
                sbq.push_back(ne);
            end else if (req != 0) begin
                chk("idle_with_req", 32'(gnt), 32'(1));
            end
        end
        last_gnt = gnt;
    end

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] exp_gnt;
        logic [AW-1:0]   exp_addr;
    } vec_t;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [10];
        logic [NREQ-1:0] rr_exp [6];
        logic [NREQ-1:0] st_exp [8];

        vt[0] = '{4'b0001, 4'b0001, 12'h0A1};
        vt[1] = '{4'b0010, 4'b0010, 12'h1B2};
        vt[2] = '{4'b0100, 4'b0100, 12'h2C3};
        vt[3] = '{4'b1000, 4'b1000, 12'h3D4};
        vt[4] = '{4'b1110, 4'b0010, 12'h1B2};
        vt[5] = '{4'b1100, 4'b0100, 12'h2C3};
        vt[6] = '{4'b1111, 4'b0001, 12'h0A1};
        vt[7] = '{4'b1010, 4'b0010, 12'h1B2};
        vt[8] = '{4'b0000, 4'b0000, 12'h000};
        vt[9] = '{4'b1001, 4'b0001, 12'h0A1};

`ifdef SPRITE_ARB_RR_EN
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
`else
        rr_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        st_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100};

        rst      = 1'b1;
        req      = 4'b1111;
        req_addr = {12'h3D4, 12'h2C3, 12'h1B2, 12'h0A1};

        // Reset held 3 cycles with every requester asking
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_gnt", 32'(gnt), 32'(0));
            chk("reset_rom_en", 32'(rom_en), 32'(0));
            chk("reset_rom_addr", 32'(rom_addr), 32'(0));
            chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("reset_rsp_data", 32'(rsp_data), 32'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", 32'(gnt), 32'(4'b0001));

        // Single-cycle selection from a fresh reset
        for (int v = 0; v < 10; v++) begin
            do_reset();
            req = vt[v].req;
            @(negedge clk);
            chk("tbl_gnt", 32'(gnt), 32'(vt[v].exp_gnt));
            chk("tbl_rom_en", 32'(rom_en), 32'(vt[v].exp_gnt != 0));
            chk("tbl_rom_addr", 32'(rom_addr), 32'(vt[v].exp_addr));
        end

        // Latency and returned data
        do_reset();
        req_addr[2*AW +: AW] = 12'h1A5;
        req = 4'b0100;
        @(negedge clk);
        chk("lat_gnt", 32'(gnt), 32'(4'b0100));
        chk("lat_rom_addr", 32'(rom_addr), 32'(12'h1A5));
        @(posedge clk); #1;
        req = '0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("lat_rsp_valid", 32'(rsp_valid), 32'((k == LAT) ? 4'b0100 : 4'b0000));
            if (k == LAT) chk("lat_rsp_data", 32'(rsp_data), 32'(rom_word(12'h1A5)));
        end

        // Low-priority sharing with requesters 1..3 held
        do_reset();
        req = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("share_gnt", 32'(gnt), 32'(rr_exp[k]));
            @(posedge clk); #1;
        end

        // Starvation guard: requester 2 forced through every SMAX+1 slots
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("starve_gnt", 32'(gnt), 32'(st_exp[k]));
            @(posedge clk); #1;
        end

        // Reset while a read is in flight
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'(4'b0010));
        @(posedge clk); #1;
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_in_rst", 32'(rsp_valid), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("midrst_rsp_after", 32'(rsp_valid), 32'(0));
        end

        // Random back-to-back traffic; requests held until granted
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
        for (int k = 0; k < LAT + 2; k++) @(negedge clk);
        chk("drain_outstanding", 32'(sbq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
